// File: rtl/ddr3_wb_arbiter.sv
// Round-robin Wishbone arbiter sharing the DDR3 controller's pipelined user port.
// Tracks accepted-but-unacked requests so acks return only to the issuing master.
module ddr3_wb_arbiter #(
  parameter int NUM_MASTERS     = 2,
  parameter int ADDR_BITS       = 24,
  parameter int DATA_BITS       = 512,
  parameter int SEL_BITS        = DATA_BITS / 8,
  parameter int AUX_WIDTH       = 16,
  parameter int MAX_OUTSTANDING = 16,
  parameter int MAX_BURST       = 32
) (
  input  logic                             i_controller_clk,
  input  logic                             i_rst,
  input  logic [NUM_MASTERS-1:0]           i_m_cyc,
  input  logic [NUM_MASTERS-1:0]           i_m_stb,
  input  logic [NUM_MASTERS-1:0]           i_m_we,
  input  logic [NUM_MASTERS*ADDR_BITS-1:0] i_m_addr,
  input  logic [NUM_MASTERS*DATA_BITS-1:0] i_m_data,
  input  logic [NUM_MASTERS*SEL_BITS-1:0]  i_m_sel,
  input  logic [NUM_MASTERS*AUX_WIDTH-1:0] i_m_aux,
  output logic [NUM_MASTERS-1:0]           o_m_stall,
  output logic [NUM_MASTERS-1:0]           o_m_ack,
  output logic [DATA_BITS-1:0]             o_m_data,
  output logic [AUX_WIDTH-1:0]             o_m_aux,
  output logic                             o_wb_cyc,
  output logic                             o_wb_stb,
  output logic                             o_wb_we,
  output logic [ADDR_BITS-1:0]             o_wb_addr,
  output logic [DATA_BITS-1:0]             o_wb_data,
  output logic [SEL_BITS-1:0]              o_wb_sel,
  output logic [AUX_WIDTH-1:0]             o_wb_aux,
  input  logic                             i_wb_stall,
  input  logic                             i_wb_ack,
  input  logic [DATA_BITS-1:0]             i_wb_data,
  input  logic [AUX_WIDTH-1:0]             i_wb_aux
);

  localparam int OW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, GRANTED, DRAIN} state_t;

  state_t          state_reg;
  logic [OW-1:0]   owner_reg;
  logic [OW-1:0]   rr_reg;
  logic [CW-1:0]   outstanding_reg;
  logic [BW-1:0]   burst_reg;

  logic [CW-1:0]          outstanding_next;
  logic [OW-1:0]          owner_inc;
  logic [OW-1:0]          pick;
  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] owner_onehot;
  logic                   any_req;
  logic                   other_req;
  logic                   own_cyc;
  logic                   own_stb;
  logic                   at_cap;
  logic                   accept;
  logic                   ack_dec;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_req
      assign req[gi]          = i_m_cyc[gi] & i_m_stb[gi];
      assign owner_onehot[gi] = (owner_reg == OW'(gi));
    end
  endgenerate

  assign any_req   = |req;
  assign other_req = |(req & ~owner_onehot);
  assign own_cyc   = i_m_cyc[owner_reg];
  assign own_stb   = i_m_stb[owner_reg];
  assign at_cap    = (outstanding_reg >= CW'(MAX_OUTSTANDING));
  assign owner_inc = (owner_reg == OW'(NUM_MASTERS - 1)) ? '0 : owner_reg + 1'b1;

  // Scan downward so the requester closest to rr (smallest offset) wins.
  always_comb begin
    int idx;
    idx  = 0;
    pick = rr_reg;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      idx = int'(rr_reg) + i;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (req[idx]) pick = OW'(idx);
    end
  end

  always_comb begin
    o_wb_cyc  = 1'b0;
    o_wb_stb  = 1'b0;
    o_wb_we   = 1'b0;
    o_wb_addr = '0;
    o_wb_data = '0;
    o_wb_sel  = '0;
    o_wb_aux  = '0;
    o_m_stall = '1;
    o_m_ack   = '0;
    o_m_data  = '0;
    o_m_aux   = '0;
    if (state_reg == GRANTED || state_reg == DRAIN) begin
      o_wb_we              = i_m_we[owner_reg];
      o_wb_addr            = i_m_addr[owner_reg*ADDR_BITS +: ADDR_BITS];
      o_wb_data            = i_m_data[owner_reg*DATA_BITS +: DATA_BITS];
      o_wb_sel             = i_m_sel[owner_reg*SEL_BITS +: SEL_BITS];
      o_wb_aux             = i_m_aux[owner_reg*AUX_WIDTH +: AUX_WIDTH];
      o_m_ack[owner_reg]   = i_wb_ack & own_cyc;
      o_m_data             = i_wb_data;
      o_m_aux              = i_wb_aux;
    end
    if (state_reg == GRANTED) begin
      o_wb_cyc             = own_cyc;
      o_wb_stb             = own_stb & own_cyc & ~at_cap;
      o_m_stall[owner_reg] = i_wb_stall | at_cap;
    end else if (state_reg == DRAIN) begin
      o_wb_cyc             = 1'b1;
    end
  end

  assign accept  = o_wb_stb & ~i_wb_stall;
  assign ack_dec = i_wb_ack & (outstanding_reg != '0);

  always_comb begin
    outstanding_next = outstanding_reg;
    case ({accept, ack_dec})
      2'b10:   outstanding_next = outstanding_reg + 1'b1;
      2'b01:   outstanding_next = outstanding_reg - 1'b1;
      default: outstanding_next = outstanding_reg;
    endcase
  end

  always_ff @(posedge i_controller_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg       <= IDLE;
      owner_reg       <= '0;
      rr_reg          <= '0;
      outstanding_reg <= '0;
      burst_reg       <= '0;
    end else begin
      outstanding_reg <= outstanding_next;
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            owner_reg <= pick;
            burst_reg <= '0;
            state_reg <= GRANTED;
          end
        end
        GRANTED: begin
          if (!own_cyc) begin
            outstanding_reg <= '0;
            rr_reg          <= owner_inc;
            state_reg       <= IDLE;
          end else begin
            if (accept) burst_reg <= burst_reg + 1'b1;
            if (accept && burst_reg == BW'(MAX_BURST - 1)) begin
              state_reg <= DRAIN;
            end else if (!own_stb && outstanding_reg == '0 && !i_wb_ack && other_req) begin
              rr_reg    <= owner_inc;
              state_reg <= IDLE;
            end
          end
        end
        DRAIN: begin
          if (!own_cyc) begin
            outstanding_reg <= '0;
            rr_reg          <= owner_inc;
            state_reg       <= IDLE;
          end else if (outstanding_next == '0) begin
            rr_reg    <= owner_inc;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_wb_arbiter.sv
// Directed bench for ddr3_wb_arbiter: two masters, small burst and outstanding limits,
// with a delayed-ack controller model driven from the main process.
module tb_ddr3_wb_arbiter;
  localparam int N  = 2;
  localparam int AB = 24;
  localparam int DB = 32;
  localparam int SB = 4;
  localparam int XB = 16;

  logic              clk;
  logic              i_rst;
  logic [N-1:0]      i_m_cyc, i_m_stb, i_m_we;
  logic [N*AB-1:0]   i_m_addr;
  logic [N*DB-1:0]   i_m_data;
  logic [N*SB-1:0]   i_m_sel;
  logic [N*XB-1:0]   i_m_aux;
  logic [N-1:0]      o_m_stall, o_m_ack;
  logic [DB-1:0]     o_m_data;
  logic [XB-1:0]     o_m_aux;
  logic              o_wb_cyc, o_wb_stb, o_wb_we;
  logic [AB-1:0]     o_wb_addr;
  logic [DB-1:0]     o_wb_data;
  logic [SB-1:0]     o_wb_sel;
  logic [XB-1:0]     o_wb_aux;
  logic              i_wb_stall, i_wb_ack;
  logic [DB-1:0]     i_wb_data;
  logic [XB-1:0]     i_wb_aux;

  ddr3_wb_arbiter #(
    .NUM_MASTERS(N), .ADDR_BITS(AB), .DATA_BITS(DB), .SEL_BITS(SB),
    .AUX_WIDTH(XB), .MAX_OUTSTANDING(3), .MAX_BURST(4)
  ) dut (
    .i_controller_clk(clk), .i_rst(i_rst),
    .i_m_cyc(i_m_cyc), .i_m_stb(i_m_stb), .i_m_we(i_m_we),
    .i_m_addr(i_m_addr), .i_m_data(i_m_data), .i_m_sel(i_m_sel), .i_m_aux(i_m_aux),
    .o_m_stall(o_m_stall), .o_m_ack(o_m_ack), .o_m_data(o_m_data), .o_m_aux(o_m_aux),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel), .o_wb_aux(o_wb_aux),
    .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_data(i_wb_data), .i_wb_aux(i_wb_aux)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Master models and controller ack scheduler
  logic          m_cyc_en [N];
  int            m_left   [N];
  int            m_idx    [N];
  logic          m_we     [N];
  logic [XB-1:0] m_aux    [N];
  logic          m_acc    [N];
  int            ack_cnt  [N];
  logic          sched    [64];
  int            cyc_n = 0;
  int            ack_delay = 3;
  logic          ack_en = 1'b0;
  logic          force_ack = 1'b0;
  logic          prev_cyc = 1'b0;
  int            grants [8];
  int            tacc   [8];
  int            n_grants = 0;
  int            drain_viol = 0;
  logic          found;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      i_m_cyc[k]              = m_cyc_en[k];
      i_m_stb[k]              = m_cyc_en[k] && (m_left[k] > 0);
      i_m_we[k]               = m_we[k];
      i_m_addr[k*AB +: AB]    = AB'(32'h100 * (k + 1) + m_idx[k]);
      i_m_data[k*DB +: DB]    = 32'hD000_0000 | 32'(m_idx[k]);
      i_m_sel[k*SB +: SB]     = '1;
      i_m_aux[k*XB +: XB]     = m_aux[k];
    end
  endtask

  task automatic tick();
    logic acc;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      m_acc[k] = i_m_cyc[k] && i_m_stb[k] && !o_m_stall[k];
      if (o_m_ack[k]) ack_cnt[k]++;
    end
    acc = o_wb_stb && !i_wb_stall;
    if (!prev_cyc && o_wb_cyc && n_grants < 8) begin
      grants[n_grants] = o_m_stall[0] ? 1 : 0;
      tacc[n_grants]   = 0;
      n_grants++;
    end
    if (n_grants > 0 && o_wb_stb && tacc[n_grants-1] >= 4) drain_viol++;
    if (acc && n_grants > 0) tacc[n_grants-1]++;
    prev_cyc = o_wb_cyc;
    if (acc && ack_en) sched[(cyc_n + ack_delay) % 64] = 1'b1;
    @(posedge clk);
    #1;
    cyc_n++;
    i_wb_ack = (ack_en && sched[cyc_n % 64]) || force_ack;
    sched[cyc_n % 64] = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (m_acc[k]) begin
        m_idx[k]++;
        m_left[k]--;
      end
    end
    drive();
  endtask

  initial begin
    i_rst = 1'b1;
    i_wb_stall = 1'b0; i_wb_ack = 1'b0; i_wb_data = '0; i_wb_aux = '0;
    for (int i = 0; i < 64; i++) sched[i] = 1'b0;
    for (int k = 0; k < N; k++) begin
      m_cyc_en[k] = 1'b0; m_left[k] = 0; m_idx[k] = 0; m_we[k] = 1'b0;
      m_aux[k] = '0; m_acc[k] = 1'b0; ack_cnt[k] = 0;
    end
    drive();
    #2;
    check("rst_cyc",   64'(o_wb_cyc), 64'd0);
    check("rst_stb",   64'(o_wb_stb), 64'd0);
    check("rst_stall", 64'(o_m_stall), 64'h3);
    check("rst_ack",   64'(o_m_ack), 64'd0);
    check("rst_addr",  64'(o_wb_addr), 64'd0);
    #10 i_rst = 1'b0;
    @(posedge clk); #1;

    // Single master: 4 writes, 3-cycle ack latency
    ack_en = 1'b1; ack_delay = 3;
    m_we[0] = 1'b1; m_left[0] = 4; m_cyc_en[0] = 1'b1; drive();
    #1 check("t1_idle_stb", 64'(o_wb_stb), 64'd0);
    tick();
    #1 check("t1_first_stb",  64'(o_wb_stb), 64'd1);
    check("t1_first_addr",    64'(o_wb_addr), 64'h100);
    check("t1_first_we",      64'(o_wb_we), 64'd1);
    check("t1_stall",         64'(o_m_stall), 64'h2);
    for (int i = 0; i < 15; i++) tick();
    check("t1_ack_m0",        64'(ack_cnt[0]), 64'd4);
    check("t1_ack_m1",        64'(ack_cnt[1]), 64'd0);
    check("t1_outstanding",   64'(dut.outstanding_reg), 64'd0);
    m_cyc_en[0] = 1'b0; drive();
    tick();
    #1 check("t1_idle_cyc",   64'(o_wb_cyc), 64'd0);
    check("t1_idle_stall",    64'(o_m_stall), 64'h3);

    // Contention: rr points at master 1 after master 0's tenure
    ack_delay = 2; ack_cnt[0] = 0; ack_cnt[1] = 0; n_grants = 0; drain_viol = 0;
    for (int k = 0; k < N; k++) begin m_left[k] = 8; m_cyc_en[k] = 1'b1; end
    drive();
    for (int i = 0; i < 60; i++) tick();
    check("t2_n_grants", 64'(n_grants), 64'd4);
    for (int g = 0; g < 4; g++) begin
      check($sformatf("t2_grant%0d", g), 64'(grants[g]), 64'((g % 2 == 0) ? 1 : 0));
      check($sformatf("t2_tacc%0d", g),  64'(tacc[g]), 64'd4);
    end
    check("t2_drain_viol", 64'(drain_viol), 64'd0);
    check("t2_ack_m0",     64'(ack_cnt[0]), 64'd8);
    check("t2_ack_m1",     64'(ack_cnt[1]), 64'd8);
    m_cyc_en[0] = 1'b0; m_cyc_en[1] = 1'b0; drive();
    tick();

    // Outstanding cap of 3 with acks withheld
    ack_en = 1'b0;
    m_left[1] = 4; m_cyc_en[1] = 1'b1; drive();
    tick(); tick(); tick(); tick();
    #1 check("t3_cap_stb",   64'(o_wb_stb), 64'd0);
    check("t3_cap_stall",    64'(o_m_stall[1]), 64'd1);
    check("t3_cap_out",      64'(dut.outstanding_reg), 64'd3);
    tick();
    #1 check("t3_cap_hold",  64'(o_wb_stb), 64'd0);
    force_ack = 1'b1;
    tick();
    #1 check("t3_ack_at_cap", 64'(o_m_ack), 64'h2);
    check("t3_stb_at_cap",   64'(o_wb_stb), 64'd0);
    tick();
    #1 check("t3_resume_stb", 64'(o_wb_stb), 64'd1);
    check("t3_resume_ack",   64'(o_m_ack), 64'h2);
    force_ack = 1'b0;
    tick();
    #1 check("t3_acc_ack_out", 64'(dut.outstanding_reg), 64'd2);
    check("t3_drain_cyc",    64'(o_wb_cyc), 64'd1);
    check("t3_drain_stb",    64'(o_wb_stb), 64'd0);
    force_ack = 1'b1;
    tick(); tick();
    force_ack = 1'b0;
    tick();
    #1 check("t3_done_cyc",  64'(o_wb_cyc), 64'd0);
    check("t3_done_out",     64'(dut.outstanding_reg), 64'd0);
    m_cyc_en[1] = 1'b0; drive();

    // Abort: master 1 drops cyc with 3 outstanding
    m_left[1] = 3; m_cyc_en[1] = 1'b1; drive();
    tick(); tick(); tick(); tick();
    m_cyc_en[1] = 1'b0; drive(); i_wb_ack = 1'b1;
    #1 check("t4_abort_cyc", 64'(o_wb_cyc), 64'd0);
    check("t4_abort_ack",    64'(o_m_ack), 64'd0);
    force_ack = 1'b1;
    tick();
    #1 check("t4_abort_out", 64'(dut.outstanding_reg), 64'd0);
    check("t4_late_ack",     64'(o_m_ack), 64'd0);
    force_ack = 1'b0; ack_cnt[0] = 0; ack_cnt[1] = 0;
    ack_en = 1'b1; ack_delay = 2;
    for (int k = 0; k < N; k++) begin m_left[k] = 1; m_cyc_en[k] = 1'b1; end
    drive();
    tick();
    #1 check("t4_next_grant", 64'(o_m_stall), 64'h2);
    for (int i = 0; i < 20; i++) tick();
    check("t4_ack_m0", 64'(ack_cnt[0]), 64'd1);
    check("t4_ack_m1", 64'(ack_cnt[1]), 64'd1);
    m_cyc_en[0] = 1'b0; m_cyc_en[1] = 1'b0; drive();
    tick(); tick();

    // Aux/data passthrough on a master-1 read
    ack_en = 1'b0;
    m_we[1] = 1'b0; m_aux[1] = 16'hBEEF; m_left[1] = 1; m_cyc_en[1] = 1'b1; drive();
    tick();
    #1 check("t5_req_aux",   64'(o_wb_aux), 64'hBEEF);
    check("t5_req_we",       64'(o_wb_we), 64'd0);
    check("t5_req_stb",      64'(o_wb_stb), 64'd1);
    tick();
    i_wb_data = 32'hA5A5_A5A5; i_wb_aux = 16'hBEEF; i_wb_ack = 1'b1;
    #1 check("t5_ack",       64'(o_m_ack), 64'h2);
    check("t5_data",         64'(o_m_data), 64'hA5A5_A5A5);
    check("t5_aux",          64'(o_m_aux), 64'hBEEF);
    tick();
    m_cyc_en[1] = 1'b0; drive();
    tick();

    // Asynchronous reset mid-DRAIN
    ack_en = 1'b1; ack_delay = 4;
    m_we[0] = 1'b1; m_left[0] = 4; m_cyc_en[0] = 1'b1; drive();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (m_left[0] == 0 && o_wb_cyc && !o_wb_stb) found = 1'b1;
    end
    check("t6_drain_reached", 64'(found), 64'd1);
    i_wb_ack = 1'b1;
    #1 check("t6_drain_ack", 64'(o_m_ack), 64'h1);
    #1 i_rst = 1'b1;
    #1;
    check("t6_rst_cyc",   64'(o_wb_cyc), 64'd0);
    check("t6_rst_stall", 64'(o_m_stall), 64'h3);
    check("t6_rst_ack",   64'(o_m_ack), 64'd0);
    check("t6_rst_data",  64'(o_m_data), 64'd0);
    check("t6_rst_aux",   64'(o_m_aux), 64'd0);
    ack_en = 1'b0; force_ack = 1'b0; i_wb_ack = 1'b0;
    for (int i = 0; i < 64; i++) sched[i] = 1'b0;
    for (int k = 0; k < N; k++) begin m_cyc_en[k] = 1'b0; m_left[k] = 0; end
    drive();
    tick(); tick();
    #2 i_rst = 1'b0;
    for (int k = 0; k < N; k++) begin m_left[k] = 1; m_cyc_en[k] = 1'b1; end
    drive();
    tick();
    #1 check("t6_post_rst_grant", 64'(o_m_stall), 64'h2);
    ack_en = 1'b1; ack_delay = 2;
    for (int i = 0; i < 12; i++) tick();
    m_cyc_en[0] = 1'b0; m_cyc_en[1] = 1'b0; drive();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
